// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with level, almost flags, sticky errors and optional FWFT.
// Latency: standard mode data_out one cycle after an accepted read; FWFT head visible the cycle after it is written.
// Backpressure: writes while full and reads while empty are dropped and raise sticky overflow/underflow.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   data_in, write_en           write data and request
//   read_en                     read request (pop/acknowledge in FWFT mode)
//   clr_err                     synchronous clear of overflow/underflow
//   data_out, rd_valid          read data and its qualifier
//   full, empty                 level == DEPTH / level == 0
//   almost_full, almost_empty   level >= AF_THRESH / level <= AE_THRESH
//   level                       number of stored entries
//   overflow, underflow         sticky error flags
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Flags decode the registered level, so acceptance uses pre-edge state:
  // a write while full is refused even if a read frees a slot this cycle.
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_THRESH));
  assign almost_empty = (level <= LW'(AE_THRESH));

  assign wr_ok = write_en && !full;
  assign rd_ok = read_en && !empty;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers are exactly AW bits, so they wrap DEPTH-1 -> 0 for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_en && full)  overflow <= 1'b1;
      else if (clr_err)      overflow <= 1'b0;
      if (read_en && empty)  underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; zero while nothing is stored.
      assign data_out = empty ? '0 : mem[rd_ptr];
      assign rd_valid = !empty;
    end else begin : g_std
      logic [DATA_W-1:0] dout_q;
      logic              vld_q;

      // Reads the pre-edge head, so a same-cycle write never bypasses.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q <= '0;
          vld_q  <= 1'b0;
        end else begin
          vld_q <= rd_ok;
          if (rd_ok) dout_q <= mem[rd_ptr];
        end
      end

      assign data_out = dout_q;
      assign rd_valid = vld_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;
  logic       clr_err = 1'b0;

  // Standard-mode instance outputs
  logic [7:0] dout_s;
  logic       rv_s, full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic [4:0] level_s;
  // FWFT instance outputs
  logic [7:0] dout_f;
  logic       rv_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0] level_f;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
    .clr_err(clr_err), .data_out(dout_s), .rd_valid(rv_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .level(level_s), .overflow(ovf_s), .underflow(unf_s)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .write_en(write_en), .read_en(read_en),
    .clr_err(clr_err), .data_out(dout_f), .rd_valid(rv_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .level(level_f), .overflow(ovf_f), .underflow(unf_f)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words plus the error flags and the
  // standard-mode output register.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_rv  = 1'b0;
  logic [7:0] m_dout = '0;

  typedef struct {
    logic       we, re, clr;
    logic [7:0] din;
    logic [4:0] lvl;
    logic       ae, ovf, unf, rv;
    logic [7:0] dout, fh;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rv = 1'b0;
    m_dout = '0;
  endtask

  // Drive one cycle, update the model from pre-edge state, settle 1 time unit past the edge.
  task automatic step(input logic we, input logic re, input logic [7:0] din, input logic clr);
    bit was_full, was_empty;
    write_en = we;
    read_en = re;
    data_in = din;
    clr_err = clr;
    @(posedge clk);
    was_full = (q.size() == 16);
    was_empty = (q.size() == 0);
    if (we && was_full) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (re && was_empty) m_unf = 1'b1;
    else if (clr) m_unf = 1'b0;
    m_rv = re && !was_empty;
    if (re && !was_empty) m_dout = q.pop_front();
    if (we && !was_full) q.push_back(din);
    #1;
  endtask

  task automatic check_model(input string tag);
    int lvl;
    lvl = q.size();
    chk({tag, ".level"}, 32'(level_s), 32'(lvl));
    chk({tag, ".full"}, 32'(full_s), 32'(lvl == 16));
    chk({tag, ".empty"}, 32'(empty_s), 32'(lvl == 0));
    chk({tag, ".almost_full"}, 32'(af_s), 32'(lvl >= 14));
    chk({tag, ".almost_empty"}, 32'(ae_s), 32'(lvl <= 2));
    chk({tag, ".overflow"}, 32'(ovf_s), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(unf_s), 32'(m_unf));
    chk({tag, ".data_out"}, 32'(dout_s), 32'(m_dout));
    chk({tag, ".rd_valid"}, 32'(rv_s), 32'(m_rv));
    chk({tag, ".fwft_level"}, 32'(level_f), 32'(lvl));
    chk({tag, ".fwft_flags"}, {28'd0, full_f, empty_f, ovf_f, unf_f},
        {28'd0, lvl == 16, lvl == 0, m_ovf, m_unf});
    chk({tag, ".fwft_almost"}, {30'd0, af_f, ae_f}, {30'd0, lvl >= 14, lvl <= 2});
    chk({tag, ".fwft_data_out"}, 32'(dout_f), (lvl == 0) ? 32'd0 : 32'(q[0]));
    chk({tag, ".fwft_rd_valid"}, 32'(rv_f), 32'(lvl != 0));
  endtask

  initial begin
    // Directed vectors applied right after reset: {we,re,clr,din | level,ae,ovf,unf,rv,dout,fwft_head}
    tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h3C, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h4D, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h5E, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 8'h4D};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 8'h6F, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h4D, 8'h5E};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h4D, 8'h5E};
    tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h4D, 8'h5E};

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset_held");
    rst = 1'b0;
    #1;
    check_model("reset_released");

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].din, tbl[i].clr);
      chk($sformatf("vec%0d.level", i), 32'(level_s), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d.almost_empty", i), 32'(ae_s), 32'(tbl[i].ae));
      chk($sformatf("vec%0d.overflow", i), 32'(ovf_s), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d.underflow", i), 32'(unf_s), 32'(tbl[i].unf));
      chk($sformatf("vec%0d.rd_valid", i), 32'(rv_s), 32'(tbl[i].rv));
      chk($sformatf("vec%0d.data_out", i), 32'(dout_s), 32'(tbl[i].dout));
      chk($sformatf("vec%0d.fwft_data_out", i), 32'(dout_f), 32'(tbl[i].fh));
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check_model("drain_after_table");

    // Fill 0x10..0x1F: almost_full at 14, full at 16, almost_empty drops at 3
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
      check_model($sformatf("fill%0d", i));
      if (i == 12) chk("fill.af_below_thresh", 32'(af_s), 32'd0);
      if (i == 13) chk("fill.af_at_thresh", 32'(af_s), 32'd1);
      if (i == 1)  chk("fill.ae_at_2", 32'(ae_s), 32'd1);
      if (i == 2)  chk("fill.ae_at_3", 32'(ae_s), 32'd0);
    end
    chk("fill.full", 32'(full_s), 32'd1);

    // Write while full: rejected, overflow sticks
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    check_model("overflow_write");
    chk("overflow.level", 32'(level_s), 32'd16);
    chk("overflow.flag", 32'(ovf_s), 32'd1);

    // Drain 16 words in order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      check_model($sformatf("drain%0d", i));
      chk($sformatf("drain%0d.order", i), 32'(dout_s), 32'(8'h10 + i));
    end

    // Read while empty: underflow, data_out held
    step(1'b0, 1'b1, 8'h00, 1'b0);
    check_model("underflow_read");
    chk("underflow.dout_held", 32'(dout_s), 32'h1F);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check_model("clr_err");

    // Level 5 with simultaneous read+write for 40 cycles (pointers wrap)
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'(8'h25 + i), 1'b0);
      check_model($sformatf("stream%0d", i));
      chk($sformatf("stream%0d.order", i), 32'(dout_s), 32'(8'h20 + i));
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    check_model("stream_drained");

    // FWFT: write into empty FIFO appears next cycle, pop returns to 0
    step(1'b1, 1'b0, 8'h55, 1'b0);
    chk("fwft.first_word", 32'(dout_f), 32'h55);
    chk("fwft.rd_valid", 32'(rv_f), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft.pop_empty", 32'(empty_f), 32'd1);
    chk("fwft.pop_dout", 32'(dout_f), 32'd0);
    check_model("fwft_pop");

    // Async reset mid-operation at level 9, with an error flag set
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h70 + i), 1'b0);
    check_model("pre_reset_level9");
    #3;
    write_en = 1'b0;
    read_en = 1'b0;
    clr_err = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("async_reset");
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic against the model, with varying fill bias
    for (int ph = 0; ph < 8; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 80 : 25;
      rp = (ph % 2 == 0) ? 30 : 80;
      for (int i = 0; i < 100; i++) begin
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
             8'($urandom), $urandom_range(0, 19) == 0);
        check_model($sformatf("rand%0d_%0d", ph, i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parameterised single-clock FIFO. It is the next-generation successor to the team's fixed 8x16 synchronous FIFO. It adds configurable width and depth, a fill-level output, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks in the same clock domain, as the common buffering primitive for the verification environments.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
AF_THRESH, 14, almost_full asserts when level >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
data_in  input  DATA_W  write data
write_en  input  1  write request
read_en  input  1  read request
clr_err  input  1  synchronous clear of the overflow and underflow flags
data_out  output  DATA_W  read data
rd_valid  output  1  data_out updated this cycle (standard mode); equals !empty in FWFT mode
full  output  1  level == DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= AF_THRESH
almost_empty  output  1  level <= AE_THRESH
level  output  $clog2(DEPTH)+1  current number of stored entries
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset (async, rst=1): pointers=0, level=0, data_out=0, rd_valid=0, overflow=0, underflow=0. Therefore empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset. Reset asserted mid-operation discards all stored data immediately.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Write acceptance: wr_ok = write_en && !full. An accepted write stores data_in at wr_ptr and increments wr_ptr.
- Read acceptance: rd_ok = read_en && !empty. An accepted read increments rd_ptr.
- full is evaluated before the edge. A write while full is rejected even if a read is accepted in the same cycle.
- Level update: wr_ok only -> +1; rd_ok only -> -1; both or neither -> unchanged.
- Simultaneous accepted read and write: both pointers advance and level holds. Read data is the pre-edge head, never the word written in the same cycle.
- Flags full, empty, almost_full, almost_empty are combinational decodes of the registered level.
- Standard mode (FWFT=0):
  - On rd_ok, data_out <= mem[rd_ptr] (one-cycle latency) and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and data_out holds its value.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] when !empty, and 0 when empty; rd_valid = !empty.
  - read_en acts as a pop/acknowledge; the next head appears the cycle after rd_ok.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
- overflow is set on write_en && full. underflow is set on read_en && empty.
- Both error flags hold until clr_err=1 or reset. If clr_err and a new error occur in the same cycle, the flag is set (the error wins).
- Rejected operations change no pointer, level or data.

Test Plan:
1. DEPTH=16, after reset: write 0x10..0x1F on consecutive cycles -> level counts 1..16; almost_full rises when level reaches 14; full=1 at level 16; almost_empty falls when level reaches 3.
2. While full, write_en=1 with 0xAA -> overflow=1, level stays 16. Then read 16 words -> data_out 0x10..0x1F in order, each one cycle after its read, rd_valid high on each; 0xAA never appears.
3. While empty, read_en=1 -> underflow=1, data_out unchanged, level 0. Then clr_err=1 alone -> underflow=0. Then clr_err=1 with read_en=1 while empty in the same cycle -> underflow stays 1.
4. At level 5, write_en=read_en=1 for 40 cycles with incrementing data -> level stays 5, pointers wrap at least twice, output sequence is correct with no loss or duplication.
5. FWFT=1: write 0x55 into an empty FIFO -> data_out=0x55 and rd_valid=1 on the next cycle with no read. Pulse read_en -> empty=1 and data_out=0 on the following cycle.
6. Fill to level 9, assert rst asynchronously between clock edges -> level=0, empty=1, data_out=0, overflow=underflow=0 immediately, before the next edge. Subsequent traffic behaves as after a fresh reset.
